// File: rtl/reg_skid_slice.sv
// Two-entry register slice: an output register plus a skid register.
// All outputs come straight from flops, so no input reaches an output combinationally.
module reg_skid_slice #(
    parameter int unsigned                 REG_WIDTH   = 1,
    parameter logic [REG_WIDTH-1:0]        REG_INITIAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    input  logic [REG_WIDTH-1:0] s_data,
    output logic                 s_ready,
    output logic                 m_valid,
    output logic [REG_WIDTH-1:0] m_data,
    input  logic                 m_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [REG_WIDTH-1:0]   m_data_d;
    logic [REG_WIDTH-1:0]   skid_data_q, skid_data_d;
    logic                   in_xfer, out_xfer;

    assign in_xfer  = s_valid && s_ready;
    assign out_xfer = m_valid && m_ready;

    always_comb begin
        state_d     = state_q;
        m_data_d    = m_data;
        skid_data_d = skid_data_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d  = ONE;
                    m_data_d = s_data;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    m_data_d = s_data;
                end else if (in_xfer) begin
                    state_d     = TWO;
                    skid_data_d = s_data;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_d  = ONE;
                    m_data_d = skid_data_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // m_valid and s_ready are flops loaded from the next state, keeping them glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            m_valid     <= 1'b0;
            s_ready     <= 1'b1;
            m_data      <= REG_INITIAL;
            skid_data_q <= REG_INITIAL;
        end else begin
            state_q     <= state_d;
            m_valid     <= (state_d != EMPTY);
            s_ready     <= (state_d != TWO);
            m_data      <= m_data_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_reg_skid_slice.sv
// Directed and randomised checks for reg_skid_slice with an 8-bit data path.
module tb_reg_skid_slice;

    localparam logic [7:0] INIT = 8'h5A;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;

    int unsigned total = 0;
    int unsigned bad   = 0;

    reg_skid_slice #(.REG_WIDTH(8), .REG_INITIAL(INIT)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [7:0] ed, input logic er);
        chk({tag, ".m_valid"}, 32'(m_valid), 32'(ev));
        chk({tag, ".m_data"},  32'(m_data),  32'(ed));
        chk({tag, ".s_ready"}, 32'(s_ready), 32'(er));
    endtask

    logic [7:0] q[$];
    int unsigned occ;
    int unsigned n_in, n_out;
    logic        iv, ov;

    initial begin
        // Reset held two cycles with a valid word presented.
        rst = 1'b1; s_valid = 1'b1; s_data = 8'hAA; m_ready = 1'b0;
        tick(); chk_out("reset1", 1'b0, INIT, 1'b1);
        tick(); chk_out("reset2", 1'b0, INIT, 1'b1);
        rst = 1'b0; s_valid = 1'b0;
        tick(); chk_out("post_reset1", 1'b0, INIT, 1'b1);
        m_ready = 1'b1;
        tick(); chk_out("post_reset2", 1'b0, INIT, 1'b1);

        // Streaming at full rate.
        for (int i = 1; i <= 10; i++) begin
            s_valid = 1'b1; s_data = 8'(i);
            tick(); chk_out("stream", 1'b1, 8'(i), 1'b1);
        end
        s_valid = 1'b0;
        tick(); chk_out("stream_end", 1'b0, 8'd10, 1'b1);

        // Backpressure fills the skid register.
        m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h11;
        tick(); chk_out("bp_first", 1'b1, 8'h11, 1'b1);
        s_data = 8'h22;
        tick(); chk_out("bp_full", 1'b1, 8'h11, 1'b0);
        s_valid = 1'b0; m_ready = 1'b1;
        tick(); chk_out("bp_drain1", 1'b1, 8'h22, 1'b1);
        tick(); chk_out("bp_drain2", 1'b0, 8'h22, 1'b1);

        // Stall with toggling upstream data while full.
        m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h66;
        tick(); chk_out("stall_fill1", 1'b1, 8'h66, 1'b1);
        s_data = 8'h77;
        tick(); chk_out("stall_fill2", 1'b1, 8'h66, 1'b0);
        for (int i = 0; i < 5; i++) begin
            s_data = (i % 2 == 0) ? 8'h88 : 8'h99;
            tick(); chk_out("stall_hold", 1'b1, 8'h66, 1'b0);
        end
        s_valid = 1'b0; m_ready = 1'b1;
        tick(); chk_out("stall_drain1", 1'b1, 8'h77, 1'b1);
        tick(); chk_out("stall_drain2", 1'b0, 8'h77, 1'b1);

        // Reset while full discards both words.
        m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h33;
        tick(); s_data = 8'h44;
        tick(); chk_out("mid_full", 1'b1, 8'h33, 1'b0);
        rst = 1'b1; s_valid = 1'b0;
        tick(); chk_out("mid_reset", 1'b0, INIT, 1'b1);
        rst = 1'b0; s_valid = 1'b1; s_data = 8'h55;
        tick(); chk_out("mid_next", 1'b1, 8'h55, 1'b1);
        s_valid = 1'b0; m_ready = 1'b1;
        tick(); chk_out("mid_empty", 1'b0, 8'h55, 1'b1);

        // Randomised traffic against a queue model.
        q.delete(); occ = 0; n_in = 0; n_out = 0;
        for (int c = 0; c < 10000; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            iv = s_valid && (occ < 2);
            ov = m_ready && (occ > 0);
            if (ov) begin void'(q.pop_front()); occ--; n_out++; end
            if (iv) begin q.push_back(s_data); occ++; n_in++; end
            tick();
            chk("rnd.m_valid", 32'(m_valid), 32'(occ > 0));
            chk("rnd.s_ready", 32'(s_ready), 32'(occ < 2));
            if (occ > 0) chk("rnd.m_data", 32'(m_data), 32'(q[0]));
        end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (occ > 0) begin void'(q.pop_front()); occ--; n_out++; end
            tick();
        end
        chk("rnd.count", 32'(n_out), 32'(n_in));
        chk("rnd.final_valid", 32'(m_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_skid_slice.md
REG_SKID_SLICE -- requirements
Module: reg_skid_slice

Interface
- REQ-001 SHALL have parameter REG_WIDTH, default 1: width of the data path in bits.
- REQ-002 SHALL have parameter REG_INITIAL, default 'b0: reset value of m_data and of the internal skid data.
- REQ-003 SHALL use one clock; reset is synchronous and active-high.
- REQ-004 clk  input  1  rising-edge clock for all state.
- REQ-005 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
- REQ-006 s_valid  input  1  upstream word is valid.
- REQ-007 s_data  input  REG_WIDTH  upstream word.
- REQ-008 s_ready  output  1  slice can accept a word; registered.
- REQ-009 m_valid  output  1  downstream word is valid; registered.
- REQ-010 m_data  output  REG_WIDTH  downstream word; registered.
- REQ-011 m_ready  input  1  downstream accepts m_data.

Function
- REQ-012 Transfer on a side SHALL occur exactly when valid and ready are both 1 at a rising edge of clk.
- REQ-013 Storage: one output register (m_data/m_valid) plus one skid register (skid_data/skid_valid); capacity 2 words.
- REQ-014 States:
  - EMPTY: m_valid=0, skid_valid=0.
  - ONE: m_valid=1, skid_valid=0.
  - TWO: m_valid=1, skid_valid=1.
- REQ-015 s_ready SHALL equal NOT skid_valid, registered: 1 in EMPTY and ONE, 0 in TWO.
- REQ-016 EMPTY + input transfer -> ONE; m_data <= s_data. Latency: word visible on m_data one cycle after acceptance.
- REQ-017 ONE + input transfer + output transfer -> ONE; m_data <= s_data (full throughput, 1 word/cycle).
- REQ-018 ONE + input transfer, no output transfer -> TWO; skid_data <= s_data; m_data held.
- REQ-019 ONE + output transfer, no input transfer -> EMPTY; m_data holds its last value.
- REQ-020 TWO + output transfer -> ONE; m_data <= skid_data; skid_valid <= 0. s_valid is ignored because s_ready=0.
- REQ-021 TWO without output transfer SHALL hold all state.
- REQ-022 Words SHALL leave in acceptance order; none SHALL be dropped or duplicated.
- REQ-023 m_data and m_valid SHALL remain stable while m_valid=1 and m_ready=0.
- REQ-024 No combinational path SHALL exist from any input to any output.
- REQ-025 m_ready=1 while m_valid=0 SHALL have no effect.

Reset
- REQ-026 While rst=1 at a clock edge:
  - m_valid <= 0, skid_valid <= 0, s_ready <= 1;
  - m_data <= REG_INITIAL, skid_data <= REG_INITIAL;
  - no transfer is counted.
- REQ-027 Reset asserted in state TWO SHALL discard both held words; the first cycle after reset SHALL show m_valid=0 and s_ready=1.
- REQ-028 All outputs SHALL be defined from the first edge with rst=1; no asynchronous behaviour is permitted.

Verification
- REQ-029 Reset: rst=1 for 2 cycles with s_valid=1, s_data=8'hAA -> m_valid=0, m_data=REG_INITIAL, s_ready=1; no word emerges after reset release.
- REQ-030 Streaming: REG_WIDTH=8, m_ready=1, s_valid=1 with data 1,2,3,...,10 on consecutive cycles -> m_data 1..10 on consecutive cycles, each one cycle after acceptance, s_ready held at 1.
- REQ-031 Backpressure: accept 8'h11, then 8'h22 with m_ready=0 -> s_ready=0 next cycle. Raise m_ready -> 8'h11 then 8'h22 output; s_ready returns to 1 after 8'h11 leaves.
- REQ-032 Stall stability: m_valid=1, m_ready=0 for 5 cycles while s_data toggles -> m_data is unchanged and no word is lost.
- REQ-033 Reset mid-operation: in state TWO holding 8'h33 and 8'h44, assert rst for 1 cycle -> m_valid=0, s_ready=1; the next accepted word 8'h55 is the first output.
- REQ-034 Random: 10^4 cycles with random s_valid and m_ready against a scoreboard -> output order and count match input exactly; valid/data are never modified while stalled.
